// File: rtl/shadow_stack_ctrl.sv
// Shadow-stack controller: pushes return addresses on retired calls, pops and
// compares them on retired returns, and tracks depth plus sticky error flags.
// Depth is kept locally so overflow/underflow are rejected without touching
// the safe-region memory.
module shadow_stack_ctrl #(
   parameter int unsigned STACK_DEPTH       = 256,
   parameter bit          UNDERFLOW_IS_VIOL = 1'b1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        guard_en,
   input  logic        ev_valid,
   output logic        ev_ready,
   input  logic        ev_is_ret,
   input  logic [31:0] ev_addr,
   output logic        ev_done,
   output logic        ev_ok,
   output logic        sr_enop,
   output logic [7:0]  sr_op,
   output logic [31:0] sr_wdata,
   input  logic [31:0] sr_rdata,
   output logic [31:0] depth,
   output logic        viol,
   output logic        ovf,
   output logic        unf,
   output logic [31:0] viol_expected,
   output logic [31:0] viol_actual,
   input  logic        err_clr
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PUSH,
      ST_POP,
      ST_CMP
   } state_e;

   localparam logic [31:0] DEPTH_MAX = 32'(STACK_DEPTH);
   localparam logic [7:0]  OP_NONE   = 8'd0;
   localparam logic [7:0]  OP_PUSH   = 8'd1;
   localparam logic [7:0]  OP_POP    = 8'd2;

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic        ev_done_q, ev_done_d;
   logic        ev_ok_q, ev_ok_d;
   logic        sr_enop_q, sr_enop_d;
   logic [7:0]  sr_op_q, sr_op_d;
   logic [31:0] sr_wdata_q, sr_wdata_d;
   logic [31:0] depth_q, depth_d;
   logic        viol_q, viol_d;
   logic        ovf_q, ovf_d;
   logic        unf_q, unf_d;
   logic [31:0] viol_exp_q, viol_exp_d;
   logic [31:0] viol_act_q, viol_act_d;
   logic        accept;

   // The controller only takes a new event while idle.
   assign ev_ready = (state_q == ST_IDLE);
   assign accept   = ev_valid && ev_ready;

   // Next-state, memory command and sticky-flag computation.
   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      state_d    = state_q;
      addr_d     = addr_q;
      ev_done_d  = 1'b0;
      ev_ok_d    = 1'b0;
      sr_enop_d  = 1'b0;
      sr_op_d    = OP_NONE;
      sr_wdata_d = sr_wdata_q;
      depth_d    = depth_q;
      viol_d     = viol_q;
      ovf_d      = ovf_q;
      unf_d      = unf_q;
      viol_exp_d = viol_exp_q;
      viol_act_d = viol_act_q;

      // Clear comes first so a coincident new error below overrides it.
      if (err_clr) begin
         viol_d     = 1'b0;
         ovf_d      = 1'b0;
         unf_d      = 1'b0;
         viol_exp_d = 32'd0;
         viol_act_d = 32'd0;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               addr_d = ev_addr;
               if (!guard_en) begin
                  ev_done_d = 1'b1;
                  ev_ok_d   = 1'b1;
               end else if (!ev_is_ret) begin
                  if (depth_q == DEPTH_MAX) begin
                     ovf_d     = 1'b1;
                     ev_done_d = 1'b1;
                     ev_ok_d   = 1'b0;
                  end else begin
                     state_d    = ST_PUSH;
                     sr_enop_d  = 1'b1;
                     sr_op_d    = OP_PUSH;
                     sr_wdata_d = ev_addr;
                     depth_d    = depth_q + 32'd1;
                  end
               end else begin
                  if (depth_q == 32'd0) begin
                     unf_d     = 1'b1;
                     ev_done_d = 1'b1;
                     ev_ok_d   = ~UNDERFLOW_IS_VIOL;
                  end else begin
                     state_d   = ST_POP;
                     sr_enop_d = 1'b1;
                     sr_op_d   = OP_POP;
                     depth_d   = depth_q - 32'd1;
                  end
               end
            end
         end
         ST_PUSH: begin
            state_d   = ST_IDLE;
            ev_done_d = 1'b1;
            ev_ok_d   = 1'b1;
         end
         ST_POP: begin
            // The safe region registers its pop data; it is valid in CMP.
            state_d = ST_CMP;
         end
         ST_CMP: begin
            state_d   = ST_IDLE;
            ev_done_d = 1'b1;
            ev_ok_d   = (sr_rdata == addr_q);
            if (sr_rdata != addr_q) begin
               viol_d = 1'b1;
               // Capture only the first mismatch, unless it is being cleared now.
               if (!viol_q || err_clr) begin
                  viol_exp_d = sr_rdata;
                  viol_act_d = addr_q;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and registered outputs; reset abandons any in-flight operation.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= ST_IDLE;
         addr_q     <= 32'd0;
         ev_done_q  <= 1'b0;
         ev_ok_q    <= 1'b0;
         sr_enop_q  <= 1'b0;
         sr_op_q    <= OP_NONE;
         sr_wdata_q <= 32'd0;
         depth_q    <= 32'd0;
         viol_q     <= 1'b0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
         viol_exp_q <= 32'd0;
         viol_act_q <= 32'd0;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so all flops update together.
         state_q    <= state_d;
         addr_q     <= addr_d;
         ev_done_q  <= ev_done_d;
         ev_ok_q    <= ev_ok_d;
         sr_enop_q  <= sr_enop_d;
         sr_op_q    <= sr_op_d;
         sr_wdata_q <= sr_wdata_d;
         depth_q    <= depth_d;
         viol_q     <= viol_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
         viol_exp_q <= viol_exp_d;
         viol_act_q <= viol_act_d;
      end
   end

   assign ev_done       = ev_done_q;
   assign ev_ok         = ev_ok_q;
   assign sr_enop       = sr_enop_q;
   assign sr_op         = sr_op_q;
   assign sr_wdata      = sr_wdata_q;
   assign depth         = depth_q;
   assign viol          = viol_q;
   assign ovf           = ovf_q;
   assign unf           = unf_q;
   assign viol_expected = viol_exp_q;
   assign viol_actual   = viol_act_q;

endmodule

// File: tb/tb_shadow_stack_ctrl.sv
// Directed bench for shadow_stack_ctrl with a small safe-region stack model.
module tb_shadow_stack_ctrl;

   logic        clk;
   logic        resetn;
   logic        guard_en;
   logic        ev_valid;
   logic        ev_ready;
   logic        ev_is_ret;
   logic [31:0] ev_addr;
   logic        ev_done;
   logic        ev_ok;
   logic        sr_enop;
   logic [7:0]  sr_op;
   logic [31:0] sr_wdata;
   logic [31:0] sr_rdata;
   logic [31:0] depth;
   logic        viol;
   logic        ovf;
   logic        unf;
   logic [31:0] viol_expected;
   logic [31:0] viol_actual;
   logic        err_clr;

   int errors = 0;
   int checks = 0;

   shadow_stack_ctrl #(
      .STACK_DEPTH      (4),
      .UNDERFLOW_IS_VIOL(1'b1)
   ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .guard_en     (guard_en),
      .ev_valid     (ev_valid),
      .ev_ready     (ev_ready),
      .ev_is_ret    (ev_is_ret),
      .ev_addr      (ev_addr),
      .ev_done      (ev_done),
      .ev_ok        (ev_ok),
      .sr_enop      (sr_enop),
      .sr_op        (sr_op),
      .sr_wdata     (sr_wdata),
      .sr_rdata     (sr_rdata),
      .depth        (depth),
      .viol         (viol),
      .ovf          (ovf),
      .unf          (unf),
      .viol_expected(viol_expected),
      .viol_actual  (viol_actual),
      .err_clr      (err_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Safe-region model: no reset, pop data registered one cycle after the pop.
   logic [31:0] mem [0:63];
   int          sp = 0;
   always @(posedge clk) begin
      if (sr_enop && sr_op == 8'd1) begin
         mem[sp[5:0]] <= sr_wdata;
         sp           <= sp + 1;
      end else if (sr_enop && sr_op == 8'd2) begin
         sr_rdata <= mem[6'(sp - 1)];
         sp       <= sp - 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Presents one event, returns latency to ev_done, ev_ok and memory-op count.
   task automatic send(input logic is_ret, input logic [31:0] addr, input logic clr,
                       output int lat, output logic ok, output int enops);
      @(negedge clk);
      ev_valid  = 1'b1;
      ev_is_ret = is_ret;
      ev_addr   = addr;
      err_clr   = clr;
      @(posedge clk);
      #1;
      ev_valid = 1'b0;
      err_clr  = 1'b0;
      lat      = 1;
      enops    = 0;
      while (!ev_done && lat < 10) begin
         if (sr_enop) enops++;
         @(posedge clk);
         #1;
         lat++;
      end
      ok = ev_ok;
   endtask

   task automatic do_ev(input string tag, input logic is_ret, input logic [31:0] addr,
                        input int exp_lat, input logic exp_ok, input int exp_enops);
      int   lat;
      logic ok;
      int   en;
      send(is_ret, addr, 1'b0, lat, ok, en);
      check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
      check({tag, ".ok"}, {31'd0, ok}, {31'd0, exp_ok});
      check({tag, ".enops"}, 32'(en), 32'(exp_enops));
   endtask

   initial begin
      int   lat;
      logic ok;
      int   en;
      resetn    = 1'b0;
      guard_en  = 1'b1;
      ev_valid  = 1'b0;
      ev_is_ret = 1'b0;
      ev_addr   = 32'd0;
      err_clr   = 1'b0;
      sr_rdata  = 32'd0;
      #23;
      check("rst.ev_ready", {31'd0, ev_ready}, 32'd1);
      check("rst.ev_done", {31'd0, ev_done}, 32'd0);
      check("rst.ev_ok", {31'd0, ev_ok}, 32'd0);
      check("rst.sr_enop", {31'd0, sr_enop}, 32'd0);
      check("rst.sr_op", {24'd0, sr_op}, 32'd0);
      check("rst.sr_wdata", sr_wdata, 32'd0);
      check("rst.depth", depth, 32'd0);
      check("rst.flags", {29'd0, viol, ovf, unf}, 32'd0);
      check("rst.viol_exp", viol_expected, 32'd0);
      check("rst.viol_act", viol_actual, 32'd0);
      @(negedge clk);
      resetn = 1'b1;

      // Matched call/return pairs.
      do_ev("call100", 1'b0, 32'h100, 2, 1'b1, 1);
      check("call100.depth", depth, 32'd1);
      do_ev("call200", 1'b0, 32'h200, 2, 1'b1, 1);
      check("call200.depth", depth, 32'd2);
      check("mem0", mem[0], 32'h100);
      check("mem1", mem[1], 32'h200);
      do_ev("ret200", 1'b1, 32'h200, 3, 1'b1, 1);
      check("ret200.depth", depth, 32'd1);
      do_ev("ret100", 1'b1, 32'h100, 3, 1'b1, 1);
      check("ret100.depth", depth, 32'd0);
      check("pair.flags", {29'd0, viol, ovf, unf}, 32'd0);

      // Mismatch capture, second mismatch keeps first capture, then clear.
      do_ev("callm", 1'b0, 32'h100, 2, 1'b1, 1);
      do_ev("retm", 1'b1, 32'h104, 3, 1'b0, 1);
      check("mis.viol", {31'd0, viol}, 32'd1);
      check("mis.exp", viol_expected, 32'h100);
      check("mis.act", viol_actual, 32'h104);
      check("mis.depth", depth, 32'd0);
      do_ev("callm2", 1'b0, 32'h500, 2, 1'b1, 1);
      do_ev("retm2", 1'b1, 32'h504, 3, 1'b0, 1);
      check("mis2.exp", viol_expected, 32'h100);
      check("mis2.act", viol_actual, 32'h104);
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check("clr.viol", {31'd0, viol}, 32'd0);
      check("clr.exp", viol_expected, 32'd0);
      check("clr.act", viol_actual, 32'd0);

      // Return at depth 0.
      do_ev("unf", 1'b1, 32'h40, 1, 1'b0, 0);
      check("unf.flag", {31'd0, unf}, 32'd1);
      check("unf.ready", {31'd0, ev_ready}, 32'd1);
      check("unf.depth", depth, 32'd0);

      // Clear coinciding with a new underflow: the set wins.
      send(1'b1, 32'h44, 1'b1, lat, ok, en);
      check("clrset.unf", {31'd0, unf}, 32'd1);
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check("clr2.unf", {31'd0, unf}, 32'd0);

      // Overflow at STACK_DEPTH=4.
      for (int i = 0; i < 4; i++) begin
         do_ev("fill", 1'b0, 32'h10 + 32'(i), 2, 1'b1, 1);
      end
      check("fill.depth", depth, 32'd4);
      do_ev("ovf5", 1'b0, 32'h14, 1, 1'b0, 0);
      check("ovf.flag", {31'd0, ovf}, 32'd1);
      check("ovf.depth", depth, 32'd4);
      for (int i = 3; i >= 0; i--) begin
         do_ev("drain", 1'b1, 32'h10 + 32'(i), 3, 1'b1, 1);
      end
      check("drain.depth", depth, 32'd0);
      check("drain.viol", {31'd0, viol}, 32'd0);

      // Guard disabled: accepted and dropped.
      guard_en = 1'b0;
      do_ev("gcall", 1'b0, 32'h700, 1, 1'b1, 0);
      do_ev("gret", 1'b1, 32'h700, 1, 1'b1, 0);
      check("g.depth", depth, 32'd0);
      guard_en = 1'b1;

      // Reset during POP.
      do_ev("rcall", 1'b0, 32'h300, 2, 1'b1, 1);
      @(negedge clk);
      ev_valid  = 1'b1;
      ev_is_ret = 1'b1;
      ev_addr   = 32'h300;
      @(posedge clk);
      #1;
      ev_valid = 1'b0;
      check("pop.enop", {31'd0, sr_enop}, 32'd1);
      #2;
      resetn = 1'b0;
      #1;
      check("mid.enop", {31'd0, sr_enop}, 32'd0);
      check("mid.depth", depth, 32'd0);
      check("mid.ready", {31'd0, ev_ready}, 32'd1);
      check("mid.flags", {29'd0, viol, ovf, unf}, 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      do_ev("pcall", 1'b0, 32'h300, 2, 1'b1, 1);
      do_ev("pret", 1'b1, 32'h300, 3, 1'b1, 1);
      check("post.depth", depth, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/shadow_stack_ctrl.md
# shadow_stack_ctrl

Initiator-side controller for the safe-region stack memory. It sits between the core's control-flow retire path and the safe region. On every retired call it pushes the return address, and on every retired return it pops the saved address and compares it with the actual return target. It tracks stack depth itself, rejects overflow and underflow without touching the memory, and reports mismatches as sticky violation flags with captured addresses.

## Interface
Parameters:
- STACK_DEPTH, 256: entry capacity of the attached safe region; must match its stack size.
- UNDERFLOW_IS_VIOL, 1: 1 = a return at depth 0 reports ev_ok=0; 0 = reports ev_ok=1 (still sets unf).

Ports:
- clk  in  1  single clock; all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- guard_en  in  1  1 = check; 0 = accept and drop events (no memory ops, ev_ok=1).
- ev_valid  in  1  core presents a call/return event.
- ev_ready  out  1  controller can accept an event (high only in IDLE).
- ev_is_ret  in  1  0 = call (ev_addr = return address to save); 1 = return (ev_addr = actual target).
- ev_addr  in  32  address for the event.
- ev_done  out  1  one-cycle pulse: event finished.
- ev_ok  out  1  result qualifier, valid with ev_done.
- sr_enop  out  1  safe-region operation enable.
- sr_op  out  8  8'd1 push, 8'd2 pop, 8'd0 when sr_enop=0.
- sr_wdata  out  32  push data.
- sr_rdata  in  32  pop data from the safe region, registered there one cycle after the pop.
- depth  out  32  live entry count.
- viol, ovf, unf  out  1 each  sticky mismatch / overflow / underflow flags.
- viol_expected, viol_actual  out  32 each  popped address and target of the first mismatch since the last clear.
- err_clr  in  1  clears viol/ovf/unf and the captured addresses.

## Operation
- States: IDLE, PUSH, POP, CMP. Handshake: accept when ev_valid && ev_ready. ev_is_ret and ev_addr are latched at acceptance.
- Call accepted:
  - guard_en=0: go to IDLE; ev_done=1, ev_ok=1.
  - depth==STACK_DEPTH: go to IDLE; no push; set ovf; ev_done=1, ev_ok=0.
  - Otherwise: go to PUSH. In PUSH, sr_enop=1, sr_op=1, sr_wdata=latched addr, and depth+1. Then go to IDLE with ev_done=1, ev_ok=1.
- Return accepted:
  - guard_en=0: go to IDLE; ev_done=1, ev_ok=1.
  - depth==0: go to IDLE; no pop issued (the safe region would ignore it and rdata would be stale); set unf; ev_ok=!UNDERFLOW_IS_VIOL.
  - Otherwise: go to POP. In POP, sr_enop=1, sr_op=2, and depth-1. Then go to CMP. In CMP, compare sr_rdata with the latched target, then go to IDLE with ev_done=1 and ev_ok=(equal).
  - On mismatch: set viol. If viol was 0, capture viol_expected=sr_rdata and viol_actual=target.
- Sticky flags:
  - err_clr clears them.
  - If err_clr coincides with a new error in the same cycle, the set wins (flag=1, new capture).
- depth arithmetic: never wraps; bounded 0..STACK_DEPTH by the checks above.

## Timing
- Reset values: state IDLE; ev_ready=1; ev_done=0; ev_ok=0; sr_enop=0; sr_op=0; sr_wdata=0; depth=0; viol=ovf=unf=0; viol_expected=viol_actual=0.
- All outputs except ev_ready are registered. ev_ready is decoded from state.
- Call accepted in cycle T:
  - T+1: PUSH, sr_enop=1, ev_ready=0.
  - T+2: ev_done, ev_ready=1.
  - Occupancy is 2 cycles.
- Return accepted in cycle T:
  - T+1: POP.
  - T+2: CMP, sr_rdata valid.
  - T+3: ev_done, ev_ready=1.
  - Occupancy is 3 cycles.
- Rejected or disabled event accepted in cycle T: ev_done at T+1, ev_ready stays 1.
- A new event may be accepted in the same cycle ev_done is high.
- sr_enop is high for exactly one cycle per memory op.
- Reset mid-operation:
  - Any in-flight op is abandoned; the outputs return to reset values immediately (asynchronous).
  - The safe region has no reset, so its internal index keeps its value. Stale entries below it are never popped, because the controller pops only while depth>0. LIFO pairing stays correct.
  - Effective capacity after such a reset is reduced. Integration resets both blocks together.

## Test plan
- Reset then call(0x100), call(0x200), ret(0x200), ret(0x100) -> pushes 0x100 then 0x200. Both returns give ev_ok=1 at T+3, depth returns 2→0, no flags set.
- Call(0x100), ret(0x104) -> ev_ok=0, viol=1, viol_expected=0x100, viol_actual=0x104, depth=0. A second mismatch does not change the captures; err_clr zeroes them.
- Return at depth 0 -> no sr_enop, unf=1, ev_done at T+1 with ev_ok=0.
- STACK_DEPTH=4: five calls -> four pushes, fifth gives ovf=1, ev_ok=0, depth stays 4.
- guard_en=0: call and ret -> ev_done/ev_ok=1 at T+1, sr_enop never asserted, depth unchanged.
- Assert resetn low during POP -> sr_enop=0 and depth=0 immediately. After release, call(0x300), ret(0x300) -> ev_ok=1.
